can_xl_tx_bit_ctrl: RTL

// Bit-timed transmit controller and bus-output mux for the CAN XL node, generalising the per-clock slzd tx mux.

---
 rtl/can_xl_tx_bit_ctrl_if.sv | 45 ++++
 rtl/can_xl_tx_bit_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/can_xl_tx_bit_ctrl_if.sv
// ---------------------------------------------------------------------------
// can_xl_tx_bit_ctrl_if
// Bundles the bit-timing strobes, frame-generator requests/bits, node status,
// bus sample and the controller outputs of the CAN XL transmit bit controller.
//   master : frame generators / bit-timing side (drives requests and strobes)
//   slave  : can_xl_tx_bit_ctrl (drives can_bus_out, tx_bit, pulses, tx_state)
// HIST_DEPTH must match the controller's HIST_DEPTH.
// ---------------------------------------------------------------------------
interface can_xl_tx_bit_ctrl_if #(
  parameter int HIST_DEPTH = 2
);
  logic                  bit_tick;
  logic                  smpl_tick;
  logic                  dt_rm_frm_tx;
  logic                  act_err_frm_tx;
  logic                  psv_err_frm_tx;
  logic                  ovld_frm_tx;
  logic                  dt_rm_out;
  logic                  err_ovld_out;
  logic                  send_ack;
  logic                  bus_off_sts;
  logic                  arbtr_sts;
  logic                  arb_field;
  logic                  can_bus_in;
  logic                  can_bus_out;
  logic [HIST_DEPTH-1:0] tx_bit;
  logic                  abort_dt_rm_tx;
  logic                  arb_lost;
  logic                  bit_err;
  logic [1:0]            tx_state;

  modport master (
    output bit_tick, smpl_tick, dt_rm_frm_tx, act_err_frm_tx, psv_err_frm_tx,
           ovld_frm_tx, dt_rm_out, err_ovld_out, send_ack, bus_off_sts,
           arbtr_sts, arb_field, can_bus_in,
    input  can_bus_out, tx_bit, abort_dt_rm_tx, arb_lost, bit_err, tx_state
  );

  modport slave (
    input  bit_tick, smpl_tick, dt_rm_frm_tx, act_err_frm_tx, psv_err_frm_tx,
           ovld_frm_tx, dt_rm_out, err_ovld_out, send_ack, bus_off_sts,
           arbtr_sts, arb_field, can_bus_in,
    output can_bus_out, tx_bit, abort_dt_rm_tx, arb_lost, bit_err, tx_state
  );
endinterface

// File: rtl/can_xl_tx_bit_ctrl.sv
// ---------------------------------------------------------------------------
// can_xl_tx_bit_ctrl
// Bit-timed transmit controller / bus-output mux for the CAN XL node.
// On bit_tick selects the bus source (error/overload > data/remote > ACK >
// recessive idle) and registers can_bus_out; at smpl_tick compares the
// driven level with can_bus_in for arbitration loss and bit errors.
// Ports:
//   clk    : system clock
//   g_rst  : asynchronous reset, active-high
//   bus    : can_xl_tx_bit_ctrl_if.slave (requests, strobes, bus in/out,
//            tx_bit history, abort/arb_lost/bit_err pulses, tx_state)
// Parameters:
//   HIST_DEPTH  : driven-bit history depth (>=2), tx_bit[0] = most recent
//   ARB_LOSS_EN : 1 = recessive-sent/dominant-read in arb field is arb loss
// ---------------------------------------------------------------------------
module can_xl_tx_bit_ctrl #(
  parameter int HIST_DEPTH  = 2,
  parameter bit ARB_LOSS_EN = 1'b1
) (
  input logic                    clk,
  input logic                    g_rst,
  can_xl_tx_bit_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DT   = 2'd1,
    S_ERR  = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_bus_out;
  logic [HIST_DEPTH-1:0] r_tx_bit;
  logic                  r_abort;
  logic                  r_arb_lost;
  logic                  r_bit_err;
  logic                  r_lost;

  logic   w_err_req, w_dt_req, w_ack_req;
  state_t w_nxt_state;
  logic   w_nxt_out;
  logic   w_arb_loss, w_chk, w_bit_err;

  assign w_err_req = (bus.act_err_frm_tx | bus.psv_err_frm_tx | bus.ovld_frm_tx) & ~bus.bus_off_sts;
  assign w_dt_req  = bus.dt_rm_frm_tx & bus.arbtr_sts & ~bus.bus_off_sts & ~r_lost;
  assign w_ack_req = ~bus.arbtr_sts & bus.send_ack & ~bus.bus_off_sts;

  // Next state at bit_tick. An error frame only ever falls back to idle, and a
  // data frame that loses its request goes idle (never straight to ACK).
  always_comb begin
    w_nxt_state = S_IDLE;
    case (r_state)
      S_ERR:   w_nxt_state = w_err_req ? S_ERR : S_IDLE;
      S_DT:    w_nxt_state = w_err_req ? S_ERR : (w_dt_req ? S_DT : S_IDLE);
      default: begin
        if (w_err_req)      w_nxt_state = S_ERR;
        else if (w_dt_req)  w_nxt_state = S_DT;
        else if (w_ack_req) w_nxt_state = S_ACK;
        else                w_nxt_state = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_nxt_out = 1'b1;
    case (w_nxt_state)
      S_ERR:   w_nxt_out = bus.err_ovld_out;
      S_DT:    w_nxt_out = bus.dt_rm_out;
      S_ACK:   w_nxt_out = 1'b0;
      default: w_nxt_out = 1'b1;
    endcase
  end

  // Sample check uses the currently driven level, so a coincident bit_tick
  // never affects the comparison. Recessive bits of an error/overload frame
  // are not checked here (passive flags may legally be overwritten).
  assign w_arb_loss = ARB_LOSS_EN && bus.smpl_tick && (r_state == S_DT) &&
                      bus.arb_field && r_bus_out && !bus.can_bus_in;
  assign w_chk      = bus.smpl_tick && (r_state != S_IDLE) &&
                      !((r_state == S_ERR) && r_bus_out);
  assign w_bit_err  = w_chk && !w_arb_loss && (r_bus_out != bus.can_bus_in);

  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) begin
      r_state    <= S_IDLE;
      r_bus_out  <= 1'b1;
      r_tx_bit   <= '1;
      r_abort    <= 1'b0;
      r_arb_lost <= 1'b0;
      r_bit_err  <= 1'b0;
      r_lost     <= 1'b0;
    end else begin
      r_abort    <= 1'b0;
      r_arb_lost <= w_arb_loss;
      r_bit_err  <= w_bit_err;

      if (w_arb_loss)             r_lost <= 1'b1;
      else if (!bus.dt_rm_frm_tx) r_lost <= 1'b0;

      // Bus-off overrides immediately, independent of bit timing.
      if (bus.bus_off_sts) begin
        r_state   <= S_IDLE;
        r_bus_out <= 1'b1;
        r_abort   <= (r_state == S_DT);
        if (bus.bit_tick) r_tx_bit <= {r_tx_bit[HIST_DEPTH-2:0], 1'b1};
      end else if (bus.bit_tick) begin
        r_state   <= w_nxt_state;
        r_bus_out <= w_nxt_out;
        r_tx_bit  <= {r_tx_bit[HIST_DEPTH-2:0], w_nxt_out};
        r_abort   <= (r_state == S_DT) && (w_nxt_state == S_ERR);
      end
    end
  end

  assign bus.can_bus_out    = r_bus_out;
  assign bus.tx_bit         = r_tx_bit;
  assign bus.abort_dt_rm_tx = r_abort;
  assign bus.arb_lost       = r_arb_lost;
  assign bus.bit_err        = r_bit_err;
  assign bus.tx_state       = r_state;

endmodule
